// File: rtl/unary_add_sched_pkg.sv
// Shared types and width helper for the unary adder scheduler.
// Used by rtl/unary_add_sched_if.sv, rtl/unary_add_sched_rr_arbiter.sv and rtl/unary_add_sched.sv.
package unary_add_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } sched_state_t;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int width_of(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/unary_add_sched_if.sv
// Request/response bundle between the binary requesters and the scheduler.
// The scheduler uses the slave modport; the requester side uses the master modport.
interface unary_add_sched_if
    import unary_add_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int LEN    = 15,
    parameter int WR_LEN = 2 * LEN
) ();
    localparam int W  = width_of(LEN);
    localparam int SW = width_of(WR_LEN);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [SW-1:0]     rsp_sum;
    logic              rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf
    );
endinterface

// File: rtl/unary_add_sched_rr_arbiter.sv
// Combinational rotating-priority arbiter: first request at or after ptr wins.
// With UNARY_ADD_SCHED_FIXED_PRIO_EN defined it becomes a lowest-index priority encoder.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

`ifdef UNARY_ADD_SCHED_FIXED_PRIO_EN
    logic unused_ptr_s;
    assign unused_ptr_s = ^ptr;
`endif

    // Scan the requesters in priority order and keep only the first hit.
    always_comb begin : arb
        int   pos;
        logic hit;
        pos   = 0;
        hit   = 1'b0;
        grant = {NREQ{1'b0}};
        idx   = {IW{1'b0}};
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef UNARY_ADD_SCHED_FIXED_PRIO_EN
            pos = k;
`else
            pos = (int'(ptr) + k) % NREQ;
`endif
            hit        = req[pos] && !any;
            grant[pos] = hit;
            idx        = hit ? IW'(pos) : idx;
            any        = any | hit;
        end
    end

endmodule

// File: rtl/unary_add_sched.sv
// Shares one serial unary adder among NREQ binary requesters: clear, stream, count back.
// Define UNARY_ADD_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module unary_add_sched
    import unary_add_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int LEN    = 15,
    parameter int WR_LEN = 2 * LEN
) (
    input  logic              clk,
    input  logic              rst,
    unary_add_sched_if.slave  bus,
    output logic              add_a,
    output logic              add_b,
    output logic              add_en,
    output logic              add_rw,
    output logic              add_rst_n,
    input  logic              add_dout,
    input  logic              add_c
);
    localparam int W  = width_of(LEN);
    localparam int SW = width_of(WR_LEN);
    localparam int IW = $clog2(NREQ);

    sched_state_t    state_r;
    logic [W-1:0]    a_lat_r;
    logic [W-1:0]    b_lat_r;
    logic            clip_r;
    logic [IW-1:0]   id_r;
    logic [SW-1:0]   cnt_r;
    logic [SW-1:0]   sum_r;
    logic            ovf_r;
    logic [IW-1:0]   rr_ptr_s;
    logic [NREQ-1:0] grant_s;
    logic [IW-1:0]   gidx_s;
    logic            any_s;
    logic [W-1:0]    a_raw_s;
    logic [W-1:0]    b_raw_s;
    logic            a_over_s;
    logic            b_over_s;
    logic [SW-1:0]   sum_nxt_s;
    logic            ovf_nxt_s;

`ifdef UNARY_ADD_SCHED_FIXED_PRIO_EN
    assign rr_ptr_s = {IW{1'b0}};
`else
    logic [IW-1:0] rr_ptr_r;
    assign rr_ptr_s = rr_ptr_r;

    // Rotate the pointer to just past each granted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= {IW{1'b0}};
        end else if (state_r == IDLE && any_s) begin
            rr_ptr_r <= (gidx_s == IW'(NREQ - 1)) ? {IW{1'b0}} : gidx_s + IW'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_s),
        .grant (grant_s),
        .idx   (gidx_s),
        .any   (any_s)
    );

    // The accept pulse is only offered while idle and never during reset.
    assign bus.req_ready = (state_r == IDLE && !rst) ? grant_s : {NREQ{1'b0}};

    assign a_raw_s   = bus.req_a[int'(gidx_s) * W +: W];
    assign b_raw_s   = bus.req_b[int'(gidx_s) * W +: W];
    assign a_over_s  = a_raw_s > W'(LEN);
    assign b_over_s  = b_raw_s > W'(LEN);
    assign ovf_nxt_s = ovf_r | add_c;

    // Count unary ones coming back from the adder, saturating at WR_LEN.
    always_comb begin
        sum_nxt_s = sum_r;
        if (add_dout && sum_r != SW'(WR_LEN)) begin
            sum_nxt_s = sum_r + SW'(1);
        end else begin
            sum_nxt_s = sum_r;
        end
    end

    // Transaction FSM; adder pins and response fields are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            a_lat_r       <= {W{1'b0}};
            b_lat_r       <= {W{1'b0}};
            clip_r        <= 1'b0;
            id_r          <= {IW{1'b0}};
            cnt_r         <= {SW{1'b0}};
            sum_r         <= {SW{1'b0}};
            ovf_r         <= 1'b0;
            add_a         <= 1'b0;
            add_b         <= 1'b0;
            add_en        <= 1'b0;
            add_rw        <= 1'b0;
            add_rst_n     <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= {IW{1'b0}};
            bus.rsp_sum   <= {SW{1'b0}};
            bus.rsp_ovf   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        a_lat_r   <= a_over_s ? W'(LEN) : a_raw_s;
                        b_lat_r   <= b_over_s ? W'(LEN) : b_raw_s;
                        clip_r    <= a_over_s | b_over_s;
                        id_r      <= gidx_s;
                        add_rst_n <= 1'b0;
                        state_r   <= CLEAR;
                    end else begin
                        add_rst_n <= 1'b1;
                    end
                end
                CLEAR: begin
                    add_rst_n <= 1'b1;
                    add_en    <= 1'b1;
                    add_rw    <= 1'b0;
                    add_a     <= a_lat_r != {W{1'b0}};
                    add_b     <= b_lat_r != {W{1'b0}};
                    cnt_r     <= {SW{1'b0}};
                    sum_r     <= {SW{1'b0}};
                    ovf_r     <= 1'b0;
                    state_r   <= READ;
                end
                READ: begin
                    ovf_r <= ovf_nxt_s;
                    if (cnt_r == SW'(LEN - 1)) begin
                        cnt_r   <= {SW{1'b0}};
                        add_a   <= 1'b0;
                        add_b   <= 1'b0;
                        add_rw  <= 1'b1;
                        state_r <= WRITE;
                    end else begin
                        // Thermometer code: stream stays high while the next index is below the operand.
                        cnt_r <= cnt_r + SW'(1);
                        add_a <= (cnt_r + SW'(1)) < SW'(a_lat_r);
                        add_b <= (cnt_r + SW'(1)) < SW'(b_lat_r);
                    end
                end
                WRITE: begin
                    ovf_r <= ovf_nxt_s;
                    sum_r <= sum_nxt_s;
                    if (cnt_r == SW'(WR_LEN - 1)) begin
                        add_en        <= 1'b0;
                        add_rw        <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_id    <= id_r;
                        bus.rsp_sum   <= sum_nxt_s;
                        bus.rsp_ovf   <= ovf_nxt_s | clip_r;
                        state_r       <= RESP;
                    end else begin
                        cnt_r <= cnt_r + SW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state_r       <= IDLE;
                    end else begin
                        bus.rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    add_a         <= 1'b0;
                    add_b         <= 1'b0;
                    add_en        <= 1'b0;
                    add_rw        <= 1'b0;
                    add_rst_n     <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unary_add_sched.sv
// Directed self-checking bench for unary_add_sched with a behavioural serial unary adder.
module tb_unary_add_sched;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    unary_add_sched_if #(.NREQ(4), .LEN(15), .WR_LEN(30)) bus ();
    logic add_a, add_b, add_en, add_rw, add_rst_n, add_dout, add_c;

    unary_add_sched #(.NREQ(4), .LEN(15), .WR_LEN(30)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .add_a(add_a), .add_b(add_b), .add_en(add_en), .add_rw(add_rw),
        .add_rst_n(add_rst_n), .add_dout(add_dout), .add_c(add_c)
    );

    // second instance with LEN=12 so a 4-bit operand can exceed LEN
    unary_add_sched_if #(.NREQ(2), .LEN(12), .WR_LEN(24)) bus2 ();
    logic a2, b2, en2, rw2, rstn2, dout2, c2;

    unary_add_sched #(.NREQ(2), .LEN(12), .WR_LEN(24)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .add_a(a2), .add_b(b2), .add_en(en2), .add_rw(rw2),
        .add_rst_n(rstn2), .add_dout(dout2), .add_c(c2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // adder model: accumulate ones while reading, replay them while writing, carry on reaching full scale
    logic [5:0] m_cnt, m_wcnt, m_nxt;
    logic       m_c;
    assign m_nxt = m_cnt + {5'd0, add_a} + {5'd0, add_b};
    always @(posedge clk) begin
        if (!add_rst_n) begin
            m_cnt <= 6'd0; m_wcnt <= 6'd0; m_c <= 1'b0;
        end else if (add_en && !add_rw) begin
            m_cnt <= m_nxt;
            m_c   <= (m_nxt >= 6'd30) && (m_cnt < 6'd30);
        end else begin
            m_c <= 1'b0;
            if (add_en && add_rw) m_wcnt <= m_wcnt + 6'd1;
        end
    end
    assign add_dout = add_en && add_rw && (m_wcnt < m_cnt);
    assign add_c    = m_c;

    logic [5:0] m2_cnt, m2_wcnt, m2_nxt;
    logic       m2_c;
    assign m2_nxt = m2_cnt + {5'd0, a2} + {5'd0, b2};
    always @(posedge clk) begin
        if (!rstn2) begin
            m2_cnt <= 6'd0; m2_wcnt <= 6'd0; m2_c <= 1'b0;
        end else if (en2 && !rw2) begin
            m2_cnt <= m2_nxt;
            m2_c   <= (m2_nxt >= 6'd24) && (m2_cnt < 6'd24);
        end else begin
            m2_c <= 1'b0;
            if (en2 && rw2) m2_wcnt <= m2_wcnt + 6'd1;
        end
    end
    assign dout2 = en2 && rw2 && (m2_wcnt < m2_cnt);
    assign c2    = m2_c;

    task automatic reset_dut();
        rst = 1'b1;
        bus.req_valid = 4'd0; bus.req_a = 16'd0; bus.req_b = 16'd0; bus.rsp_ready = 1'b1;
        bus2.req_valid = 2'd0; bus2.req_a = 8'd0; bus2.req_b = 8'd0; bus2.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // one isolated transaction on dut, measured over a 60-cycle window
    task automatic run_one(input int g, input logic [3:0] a, input logic [3:0] b,
                           output logic [3:0] rdy, output int na, output int nb, output int nrst,
                           output int dt, output logic [4:0] sum, output logic [1:0] id, output logic ovf);
        int  t0;
        bit  seen;
        @(negedge clk);
        bus.req_valid = 4'd0; bus.req_valid[g] = 1'b1;
        bus.req_a = 16'd0; bus.req_a[g*4 +: 4] = a;
        bus.req_b = 16'd0; bus.req_b[g*4 +: 4] = b;
        bus.rsp_ready = 1'b1;
        #1;
        rdy = bus.req_ready; t0 = cyc;
        na = 0; nb = 0; nrst = 0; dt = -1; seen = 1'b0; sum = 5'd0; id = 2'd0; ovf = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            bus.req_valid = 4'd0;
            if (add_a) na++;
            if (add_b) nb++;
            if (!add_rst_n) nrst++;
            if (bus.rsp_valid && !seen) begin
                seen = 1'b1; dt = cyc - t0;
                sum = bus.rsp_sum; id = bus.rsp_id; ovf = bus.rsp_ovf;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 4'hF; bus.req_a = 16'd0; bus.req_b = 16'd0; bus.rsp_ready = 1'b1;
        bus2.req_valid = 2'd0; bus2.req_a = 8'd0; bus2.req_b = 8'd0; bus2.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_ovf,
             add_a, add_b, add_en, add_rw, add_rst_n} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_values: got %b want all zero", {bus.req_ready, bus.rsp_valid, bus.rsp_id,
                     bus.rsp_sum, bus.rsp_ovf, add_a, add_b, add_en, add_rw, add_rst_n});
        end
        rst = 1'b0; bus.req_valid = 4'd0;
        @(negedge clk);
        n_tests++;
        if ({add_rst_n, add_en, bus.req_ready} !== 6'b100000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b want 100000", {add_rst_n, add_en, bus.req_ready});
        end
    endtask

    task automatic test_single();
        logic [3:0] rdy; int na, nb, nrst, dt; logic [4:0] sum; logic [1:0] id; logic ovf;
        run_one(0, 4'd3, 4'd5, rdy, na, nb, nrst, dt, sum, id, ovf);
        n_tests++; if (rdy !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", rdy); end
        n_tests++; if (na !== 3) begin n_fail++; $display("FAIL single_a_ones: got %0d want 3", na); end
        n_tests++; if (nb !== 5) begin n_fail++; $display("FAIL single_b_ones: got %0d want 5", nb); end
        n_tests++; if (nrst !== 1) begin n_fail++; $display("FAIL single_clear: got %0d want 1", nrst); end
        n_tests++; if (dt !== 47) begin n_fail++; $display("FAIL single_latency: got %0d want 47", dt); end
        n_tests++; if (sum !== 5'd8) begin n_fail++; $display("FAIL single_sum: got %0d want 8", sum); end
        n_tests++; if (id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d want 0", id); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL single_ovf: got %0d want 0", ovf); end
    endtask

    task automatic test_backpressure();
        logic [4:0] s0; logic [1:0] i0; logic o0; int bad;
        @(negedge clk);
        bus.rsp_ready = 1'b0; bus.req_valid = 4'b0100;
        bus.req_a = 16'h0100; bus.req_b = 16'h0100;
        #1;
        n_tests++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant: got %b want 0100", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'd0;
        for (int k = 0; k < 60 && !bus.rsp_valid; k++) @(negedge clk);
        n_tests++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_timeout: got %0d want 1", bus.rsp_valid); end
        s0 = bus.rsp_sum; i0 = bus.rsp_id; o0 = bus.rsp_ovf;
        n_tests++;
        if ({s0, i0, o0} !== {5'd2, 2'd2, 1'b0}) begin
            n_fail++; $display("FAIL bp_result: got sum %0d id %0d ovf %0d want 2 2 0", s0, i0, o0);
        end
        bus.req_valid = 4'b0001;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.rsp_ovf} !== {1'b1, s0, i0, o0} ||
                bus.req_ready !== 4'd0) bad++;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d bad cycles want 0", bad); end
        bus.rsp_ready = 1'b1;
        #1;
        n_tests++; if (bus.req_ready !== 4'd0) begin n_fail++; $display("FAIL bp_no_early_grant: got %b want 0000", bus.req_ready); end
        @(negedge clk);
        n_tests++;
        if ({bus.rsp_valid, bus.req_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL bp_release: got %b want 00001", {bus.rsp_valid, bus.req_ready});
        end
        @(negedge clk);
        bus.req_valid = 4'd0;
        repeat (50) @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [3:0] rdy; int na, nb, nrst, dt; logic [4:0] sum; logic [1:0] id; logic ovf;
        run_one(3, 4'd15, 4'd15, rdy, na, nb, nrst, dt, sum, id, ovf);
        n_tests++; if (rdy !== 4'b1000) begin n_fail++; $display("FAIL ovf_grant: got %b want 1000", rdy); end
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0d want 1", ovf); end
        n_tests++; if (sum !== 5'd30) begin n_fail++; $display("FAIL ovf_sum: got %0d want 30", sum); end
        n_tests++; if (id !== 2'd3) begin n_fail++; $display("FAIL ovf_id: got %0d want 3", id); end
    endtask

    task automatic test_zero();
        logic [3:0] rdy; int na, nb, nrst, dt; logic [4:0] sum; logic [1:0] id; logic ovf;
        run_one(1, 4'd0, 4'd0, rdy, na, nb, nrst, dt, sum, id, ovf);
        n_tests++; if (rdy !== 4'b0010) begin n_fail++; $display("FAIL zero_grant: got %b want 0010", rdy); end
        n_tests++; if (na + nb !== 0) begin n_fail++; $display("FAIL zero_streams: got %0d want 0", na + nb); end
        n_tests++; if (nrst !== 1) begin n_fail++; $display("FAIL zero_clear: got %0d want 1", nrst); end
        n_tests++; if (sum !== 5'd0) begin n_fail++; $display("FAIL zero_sum: got %0d want 0", sum); end
        n_tests++; if (dt !== 47) begin n_fail++; $display("FAIL zero_latency: got %0d want 47", dt); end
    endtask

    task automatic test_mid_reset();
        int t0; int nrsp;
        @(negedge clk);
        bus.req_valid = 4'b0010; bus.req_a = 16'h0020; bus.req_b = 16'h0020; bus.rsp_ready = 1'b1;
        #1;
        t0 = cyc;
        n_tests++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL mr_grant: got %b want 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'd0;
        while (cyc < t0 + 22) @(negedge clk);
        n_tests++; if ({add_en, add_rw} !== 2'b11) begin n_fail++; $display("FAIL mr_in_write: got %b want 11", {add_en, add_rw}); end
        rst = 1'b1; bus.req_valid = 4'hF;
        #1;
        n_tests++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_ovf,
             add_a, add_b, add_en, add_rw, add_rst_n} !== 17'd0) begin
            n_fail++;
            $display("FAIL mr_reset_values: got %b want all zero", {bus.req_ready, bus.rsp_valid, bus.rsp_id,
                     bus.rsp_sum, bus.rsp_ovf, add_a, add_b, add_en, add_rw, add_rst_n});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mr_next_grant: got %b want 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'd0;
        nrsp = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.rsp_valid) nrsp++;
        end
        n_tests++; if (nrsp !== 0) begin n_fail++; $display("FAIL mr_no_response: got %0d want 0", nrsp); end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        logic [3:0] got;
        int t [5];
        int k;
`ifdef UNARY_ADD_SCHED_FIXED_PRIO_EN
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        reset_dut();
        @(negedge clk);
        bus.req_valid = 4'hF; bus.req_a = 16'h4321; bus.req_b = 16'h1111; bus.rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            k = 0;
            while (bus.req_ready == 4'd0 && k < 100) begin
                @(negedge clk); #1; k++;
            end
            got = bus.req_ready; t[n] = cyc;
            n_tests++;
            if (got !== exp_g[n]) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", n, got, exp_g[n]); end
            if (n > 0) begin
                n_tests++;
                if (t[n] - t[n-1] !== 48) begin
                    n_fail++; $display("FAIL rr_period%0d: got %0d want 48", n, t[n] - t[n-1]);
                end
            end
            @(negedge clk);
        end
        bus.req_valid = 4'd0;
        repeat (50) @(negedge clk);
    endtask

    task automatic test_clip();
        int t0, na, dt; bit seen; logic [4:0] sum; logic id, ovf;
        @(negedge clk);
        bus2.req_valid = 2'b10; bus2.req_a = {4'd14, 4'd0}; bus2.req_b = {4'd2, 4'd0}; bus2.rsp_ready = 1'b1;
        #1;
        t0 = cyc;
        n_tests++; if (bus2.req_ready !== 2'b10) begin n_fail++; $display("FAIL clip_grant: got %b want 10", bus2.req_ready); end
        na = 0; dt = -1; seen = 1'b0; sum = 5'd0; id = 1'b0; ovf = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            bus2.req_valid = 2'd0;
            if (a2) na++;
            if (bus2.rsp_valid && !seen) begin
                seen = 1'b1; dt = cyc - t0; sum = bus2.rsp_sum; id = bus2.rsp_id; ovf = bus2.rsp_ovf;
            end
        end
        n_tests++; if (na !== 12) begin n_fail++; $display("FAIL clip_a_ones: got %0d want 12", na); end
        n_tests++; if (dt !== 38) begin n_fail++; $display("FAIL clip_latency: got %0d want 38", dt); end
        n_tests++; if (sum !== 5'd14) begin n_fail++; $display("FAIL clip_sum: got %0d want 14", sum); end
        n_tests++; if ({id, ovf} !== 2'b11) begin n_fail++; $display("FAIL clip_id_ovf: got %b want 11", {id, ovf}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_zero();
        test_mid_reset();
        test_round_robin();
        test_clip();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
